mult_fu_pipe: RTL and testbench

Integer multiply functional unit for the R10K-style out-of-order core. It receives one issued multiply packet (ISSUE_FU_PACKET) per cycle from the issue stage. It computes the RV32M multiply result in a fixed-depth pipeline and presents a FU_COMPLETE_PACKET to the complete stage. The complete stage can back-pressure it with complete_stall.

---
 rtl/mult_fu_pipe_pkg.sv | 55 +++++
 rtl/mult_fu_pipe_stage.sv | 35 +++
 rtl/mult_fu_pipe.sv | 79 +++++++
 tb/tb_mult_fu_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_fu_pipe_pkg.sv
// rtl/mult_fu_pipe_pkg.sv - shared types for the pipelined integer multiply unit
package mult_fu_pipe_pkg;

  localparam int XLEN  = 32;
  localparam int PR_W  = 6;
  localparam int ROB_W = 5;

  typedef enum logic [1:0] {
    MULT   = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } MULT_FUNC;

  typedef struct packed {
    MULT_FUNC mult;
  } FU_OP_SEL;

  typedef struct packed {
    logic             valid;
    FU_OP_SEL         op_sel;
    logic [XLEN-1:0]  r1_value;
    logic [XLEN-1:0]  r2_value;
    logic [PR_W-1:0]  dest_pr;
    logic [ROB_W-1:0] rob_entry;
    logic             halt;
  } ISSUE_FU_PACKET;

  typedef struct packed {
    logic             if_take_branch;
    logic             valid;
    logic             halt;
    logic [XLEN-1:0]  target_pc;
    logic [PR_W-1:0]  dest_pr;
    logic [XLEN-1:0]  dest_value;
    logic [ROB_W-1:0] rob_entry;
  } FU_COMPLETE_PACKET;

  // One pipeline slot: bookkeeping fields plus the running shift-and-add state.
  typedef struct packed {
    logic              valid;
    MULT_FUNC          op;
    logic [PR_W-1:0]   dest_pr;
    logic [ROB_W-1:0]  rob_entry;
    logic              halt;
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] mplier;
  } MULT_STAGE_T;

  function automatic logic [2*XLEN-1:0] extend_operand(logic [XLEN-1:0] v, logic is_signed);
    return is_signed ? {{XLEN{v[XLEN-1]}}, v} : {{XLEN{1'b0}}, v};
  endfunction

endpackage

// File: rtl/mult_fu_pipe_stage.sv
// rtl/mult_fu_pipe_stage.sv - one registered multiply stage consuming SLICE_W multiplier bits
module mult_fu_pipe_stage
  import mult_fu_pipe_pkg::*;
#(
  parameter int SLICE_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  input  MULT_STAGE_T stage_i,
  output MULT_STAGE_T stage_o
);

  MULT_STAGE_T stage_d;
  MULT_STAGE_T stage_q;

  always_comb begin
    stage_d         = stage_i;
    stage_d.product = stage_i.product
                    + (stage_i.mcand * {{(2*XLEN-SLICE_W){1'b0}}, stage_i.mplier[SLICE_W-1:0]});
    stage_d.mcand   = stage_i.mcand << SLICE_W;
    stage_d.mplier  = stage_i.mplier >> SLICE_W;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else if (advance) begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/mult_fu_pipe.sv
// rtl/mult_fu_pipe.sv - RV32M multiply functional unit, NUM_STAGE-deep stallable pipeline
module mult_fu_pipe
  import mult_fu_pipe_pkg::*;
#(
  parameter int NUM_STAGE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              complete_stall,
  input  ISSUE_FU_PACKET    fu_packet_in,
  output logic              fu_ready,
  output logic              want_to_complete,
  output FU_COMPLETE_PACKET fu_packet_out
);

  localparam int SLICE_W = (2 * XLEN) / NUM_STAGE;

  MULT_STAGE_T stage_in  [NUM_STAGE];
  MULT_STAGE_T stage_out [NUM_STAGE];
  MULT_STAGE_T issue_stage;
  MULT_STAGE_T last;
  logic        advance;
  logic        r1_signed;
  logic        r2_signed;
  logic        unused_tail;

  // Sign-extending to 2*XLEN lets one modulo-2^64 product serve all four ops.
  always_comb begin
    r1_signed = (fu_packet_in.op_sel.mult != MULHU);
    r2_signed = (fu_packet_in.op_sel.mult == MULT) || (fu_packet_in.op_sel.mult == MULH);

    issue_stage           = '0;
    issue_stage.valid     = fu_packet_in.valid;
    issue_stage.op        = fu_packet_in.op_sel.mult;
    issue_stage.dest_pr   = fu_packet_in.dest_pr;
    issue_stage.rob_entry = fu_packet_in.rob_entry;
    issue_stage.halt      = fu_packet_in.halt;
    issue_stage.mcand     = extend_operand(fu_packet_in.r1_value, r1_signed);
    issue_stage.mplier    = extend_operand(fu_packet_in.r2_value, r2_signed);
  end

  assign stage_in[0] = issue_stage;

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign stage_in[k] = stage_out[k-1];
    end
    mult_fu_pipe_stage #(
      .SLICE_W (SLICE_W)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .advance (advance),
      .stage_i (stage_in[k]),
      .stage_o (stage_out[k])
    );
  end

  assign last             = stage_out[NUM_STAGE-1];
  assign advance          = !(last.valid && complete_stall);
  assign fu_ready         = advance;
  assign want_to_complete = last.valid;

  always_comb begin
    fu_packet_out = '0;
    if (last.valid) begin
      fu_packet_out.valid      = 1'b1;
      fu_packet_out.halt       = last.halt;
      fu_packet_out.dest_pr    = last.dest_pr;
      fu_packet_out.rob_entry  = last.rob_entry;
      fu_packet_out.dest_value = (last.op == MULT) ? last.product[XLEN-1:0]
                                                   : last.product[2*XLEN-1:XLEN];
    end
  end

  // The final stage's shifted operands have no consumer.
  assign unused_tail = ^{last.mcand, last.mplier};

endmodule

// File: tb/tb_mult_fu_pipe.sv
// tb/tb_mult_fu_pipe.sv - self-checking bench for mult_fu_pipe
module tb_mult_fu_pipe;
  import mult_fu_pipe_pkg::*;

  localparam int N = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              complete_stall = 1'b0;
  ISSUE_FU_PACKET    fu_packet_in;
  logic              fu_ready;
  logic              want_to_complete;
  FU_COMPLETE_PACKET fu_packet_out;

  int checks = 0;
  int errors = 0;

  FU_COMPLETE_PACKET mdl [N];
  logic              last_accept = 1'b0;

  typedef struct {
    MULT_FUNC    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [12];

  mult_fu_pipe #(.NUM_STAGE(N)) dut (
    .clock            (clock),
    .reset            (reset),
    .complete_stall   (complete_stall),
    .fu_packet_in     (fu_packet_in),
    .fu_ready         (fu_ready),
    .want_to_complete (want_to_complete),
    .fu_packet_out    (fu_packet_out)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mathematical product of the operands as interpreted by the op.
  function automatic logic [31:0] ref_result(MULT_FUNC op, logic [31:0] a, logic [31:0] b);
    logic signed [127:0] va, vb, p;
    if (op != MULHU) va = $signed(a);
    else             va = $signed({1'b0, a});
    if (op == MULT || op == MULH) vb = $signed(b);
    else                          vb = $signed({1'b0, b});
    p = va * vb;
    return (op == MULT) ? p[31:0] : p[63:32];
  endfunction

  function automatic FU_COMPLETE_PACKET expect_pkt(ISSUE_FU_PACKET p);
    FU_COMPLETE_PACKET e;
    e = '0;
    if (p.valid) begin
      e.valid      = 1'b1;
      e.halt       = p.halt;
      e.dest_pr    = p.dest_pr;
      e.rob_entry  = p.rob_entry;
      e.dest_value = ref_result(p.op_sel.mult, p.r1_value, p.r2_value);
    end
    return e;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < N; k++) mdl[k] = '0;
  endtask

  task automatic model_edge();
    last_accept = 1'b0;
    if (!reset) begin
      clear_model();
    end else if (!(mdl[N-1].valid && complete_stall)) begin
      for (int k = N - 1; k > 0; k--) mdl[k] = mdl[k-1];
      mdl[0] = expect_pkt(fu_packet_in);
      last_accept = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("fu_ready", 128'(fu_ready), 128'(!(mdl[N-1].valid && complete_stall)));
    chk("want_to_complete", 128'(want_to_complete), 128'(mdl[N-1].valid));
    chk("fu_packet_out", 128'(fu_packet_out), 128'(mdl[N-1]));
  endtask

  task automatic cycle();
    #1 check_outputs();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic set_pkt(MULT_FUNC op, logic [31:0] a, logic [31:0] b,
                         logic [5:0] pr, logic [4:0] rob, logic h);
    fu_packet_in             = '0;
    fu_packet_in.valid       = 1'b1;
    fu_packet_in.op_sel.mult = op;
    fu_packet_in.r1_value    = a;
    fu_packet_in.r2_value    = b;
    fu_packet_in.dest_pr     = pr;
    fu_packet_in.rob_entry   = rob;
    fu_packet_in.halt        = h;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] corner [4];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hffff_ffff;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7fff_ffff;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int exp_b2b [4];

    vecs[0]  = '{MULT,   32'h0000_1f1e, 32'hffff_ffff, 32'hffff_e0e2};
    vecs[1]  = '{MULT,   32'h8930_1f1e, 32'hffff_ffff, 32'h76cf_e0e2};
    vecs[2]  = '{MULH,   32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000};
    vecs[3]  = '{MULHSU, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff};
    vecs[4]  = '{MULHU,  32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe};
    vecs[5]  = '{MULT,   32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
    vecs[6]  = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[7]  = '{MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hc000_0000};
    vecs[8]  = '{MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    vecs[9]  = '{MULT,   32'h7fff_ffff, 32'h7fff_ffff, 32'h0000_0001};
    vecs[10] = '{MULH,   32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{MULHSU, 32'h0000_0002, 32'hffff_ffff, 32'h0000_0001};
    exp_b2b  = '{6, 20, 42, 72};

    fu_packet_in = '0;
    clear_model();

    // Reset held, then idle
    repeat (3) cycle();
    reset = 1'b1;
    repeat (4) cycle();

    // Single MULT, no stall: exactly one valid cycle at E+3
    set_pkt(MULT, 32'h0000_1f1e, 32'hffff_ffff, 6'd32, 5'd6, 1'b0);
    cycle();
    fu_packet_in = '0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      chk("t2_want", 128'(want_to_complete), 128'(i == 3));
      if (i == 3) begin
        chk("t2_value", 128'(fu_packet_out.dest_value), 128'(32'hffff_e0e2));
        chk("t2_dest_pr", 128'(fu_packet_out.dest_pr), 128'(6'd32));
        chk("t2_rob", 128'(fu_packet_out.rob_entry), 128'(5'd6));
        chk("t2_branch", 128'(fu_packet_out.if_take_branch), 128'(0));
      end else begin
        chk("t2_idle_pkt", 128'(fu_packet_out), 128'(0));
      end
    end

    // Stalled completion holds the result and drops fu_ready
    set_pkt(MULT, 32'h8930_1f1e, 32'hffff_ffff, 6'd7, 5'd9, 1'b0);
    complete_stall = 1'b1;
    cycle();
    fu_packet_in = '0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      #1;
      chk("t3_want", 128'(want_to_complete), 128'(i >= 3));
      chk("t3_ready", 128'(fu_ready), 128'(i < 3));
      if (i >= 3) chk("t3_value", 128'(fu_packet_out.dest_value), 128'(32'h76cf_e0e2));
    end
    complete_stall = 1'b0;
    #1;
    chk("t3_release_ready", 128'(fu_ready), 128'(1));
    chk("t3_release_want", 128'(want_to_complete), 128'(1));
    cycle();
    chk("t3_drained", 128'(fu_packet_out), 128'(0));

    // Table of directed vectors with latency check
    for (int v = 0; v < 12; v++) begin
      set_pkt(vecs[v].op, vecs[v].a, vecs[v].b, 6'(v), 5'(v), v[0]);
      cycle();
      fu_packet_in = '0;
      lat = 0;
      while (!want_to_complete && lat < 10) begin
        cycle();
        lat++;
      end
      chk($sformatf("vec%0d_latency", v), 128'(lat), 128'(N - 1));
      chk($sformatf("vec%0d_value", v), 128'(fu_packet_out.dest_value), 128'(vecs[v].exp));
      chk($sformatf("vec%0d_halt", v), 128'(fu_packet_out.halt), 128'(v[0]));
    end
    cycle();

    // Back-to-back issue, results on consecutive cycles in order
    for (int i = 0; i < 4; i++) begin
      set_pkt(MULT, 32'(2 + 2 * i), 32'(3 + 2 * i), 6'(40 + i), 5'(20 + i), 1'b0);
      cycle();
    end
    fu_packet_in = '0;
    for (int j = 0; j < 4; j++) begin
      chk("b2b_want", 128'(want_to_complete), 128'(1));
      chk("b2b_value", 128'(fu_packet_out.dest_value), 128'(exp_b2b[j]));
      chk("b2b_rob", 128'(fu_packet_out.rob_entry), 128'(20 + j));
      cycle();
    end
    chk("b2b_after", 128'(want_to_complete), 128'(0));

    // Reset in flight discards the packets in the pipe
    set_pkt(MULT, 32'd11, 32'd13, 6'd1, 5'd1, 1'b0);
    cycle();
    set_pkt(MULHU, 32'hffff_ffff, 32'd5, 6'd2, 5'd2, 1'b0);
    cycle();
    fu_packet_in = '0;
    #2 reset = 1'b0;
    #1;
    clear_model();
    chk("rst_pkt", 128'(fu_packet_out), 128'(0));
    chk("rst_want", 128'(want_to_complete), 128'(0));
    chk("rst_ready", 128'(fu_ready), 128'(1));
    @(negedge clock);
    cycle();
    reset = 1'b1;
    repeat (5) cycle();
    set_pkt(MULT, 32'd12, 32'd12, 6'd3, 5'd3, 1'b1);
    cycle();
    fu_packet_in = '0;
    lat = 0;
    while (!want_to_complete && lat < 10) begin
      cycle();
      lat++;
    end
    chk("post_rst_latency", 128'(lat), 128'(N - 1));
    chk("post_rst_value", 128'(fu_packet_out.dest_value), 128'(144));
    cycle();

    // Randomized traffic against the reference model
    for (int c = 0; c < 500; c++) begin
      if (last_accept || !fu_packet_in.valid) begin
        if ($urandom_range(0, 3) != 0)
          set_pkt(MULT_FUNC'(2'($urandom_range(0, 3))), rand_operand(), rand_operand(),
                  6'($urandom), 5'($urandom), 1'($urandom));
        else
          fu_packet_in = '0;
      end
      complete_stall = ($urandom_range(0, 2) == 0);
      cycle();
    end
    complete_stall = 1'b0;
    fu_packet_in = '0;
    repeat (6) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
